led_pattern_gen: RTL

//  Parametrised LED pattern engine; successor to the free-running board blinker.

---
 rtl/led_pattern_pkg.sv | 17 +
 rtl/tick_divider.sv | 41 ++++
 rtl/led_pattern_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern engine: mode codes, scan FSM states
// and the breathe level width.
package led_pattern_pkg;

    localparam logic [1:0] MODE_COUNT   = 2'd0;
    localparam logic [1:0] MODE_SCAN    = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    typedef enum logic {
        SCAN_UP   = 1'b0,
        SCAN_DOWN = 1'b1
    } scan_state_t;

    localparam int LEVEL_BITS = 4;

endpackage

// File: rtl/tick_divider.sv
// Prescaler: counts 0..DIV-1 while enabled and emits a registered one-cycle
// tick in the cycle after the terminal count. clr restarts it with no tick.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled step tick drives COUNT, SCAN, BLINK or PWM
// BREATHE patterns onto N_LEDS registered outputs.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int CLK_HZ   = 12000000,
    parameter int TICK_HZ  = 8,
    parameter int N_LEDS   = 4,
    parameter int PWM_BITS = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        MODE,
    input  logic              PAUSE,
    output logic [N_LEDS-1:0] LED,
    output logic              TICK
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [POS_W-1:0]      POS_LAST  = POS_W'(N_LEDS - 1);
    localparam logic [LEVEL_BITS-1:0] LEVEL_MAX = '1;

    if (DIV < 2) begin : g_chk_div
        $error("led_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (PWM_BITS < LEVEL_BITS) begin : g_chk_pwm
        $error("led_pattern_gen: PWM_BITS must be at least 4");
    end
    if (N_LEDS < 1) begin : g_chk_leds
        $error("led_pattern_gen: N_LEDS must be at least 1");
    end

    logic [1:0]            r_mode;
    logic [N_LEDS-1:0]     r_step;
    scan_state_t           r_scan_state;
    logic [POS_W-1:0]      r_pos;
    logic [LEVEL_BITS-1:0] r_level;
    logic                  r_rising;
    logic [PWM_BITS-1:0]   r_pwm;
    logic [N_LEDS-1:0]     r_led;

    logic                  w_mode_chg;
    logic                  w_tick;
    logic                  w_step_en;
    logic [N_LEDS-1:0]     w_step_next;
    scan_state_t           w_scan_state_next;
    logic [POS_W-1:0]      w_pos_next;
    logic [LEVEL_BITS-1:0] w_level_next;
    logic                  w_rising_next;
    logic [PWM_BITS-1:0]   w_duty;
    logic [N_LEDS-1:0]     w_led_next;

    // A mode change restarts the prescaler and wins over PAUSE.
    assign w_mode_chg = (MODE != r_mode);
    assign w_step_en  = w_tick && !PAUSE;

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .CLK  (CLK),
        .RST  (RST),
        .en   (!PAUSE),
        .clr  (w_mode_chg),
        .tick (w_tick)
    );

    // Scan FSM, process 1 of 3: state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_scan_state <= SCAN_UP;
            r_pos        <= '0;
        end else begin
            r_scan_state <= w_scan_state_next;
            r_pos        <= w_pos_next;
        end
    end

    // Scan FSM, process 2 of 3: next state.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_scan_state_next = r_scan_state;
        w_pos_next        = r_pos;
        if (w_mode_chg) begin
            w_scan_state_next = SCAN_UP;
            w_pos_next        = '0;
        end else if (w_step_en && (N_LEDS > 1)) begin
            case (r_scan_state)
                SCAN_UP: begin
                    if (r_pos == POS_LAST) begin
                        w_scan_state_next = SCAN_DOWN;
                        w_pos_next        = r_pos - 1'b1;
                    end else begin
                        w_pos_next = r_pos + 1'b1;
                    end
                end
                SCAN_DOWN: begin
                    if (r_pos == '0) begin
                        w_scan_state_next = SCAN_UP;
                        w_pos_next        = r_pos + 1'b1;
                    end else begin
                        w_pos_next = r_pos - 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_step_next = r_step;
        if (w_mode_chg) begin
            w_step_next = '0;
        end else if (w_step_en) begin
            w_step_next = r_step + 1'b1;
        end
    end

    always_comb begin
        w_level_next  = r_level;
        w_rising_next = r_rising;
        if (w_mode_chg) begin
            w_level_next  = '0;
            w_rising_next = 1'b1;
        end else if (w_step_en) begin
            if (r_rising) begin
                if (r_level == LEVEL_MAX) begin
                    w_rising_next = 1'b0;
                    w_level_next  = r_level - 1'b1;
                end else begin
                    w_level_next = r_level + 1'b1;
                end
            end else begin
                if (r_level == '0) begin
                    w_rising_next = 1'b1;
                    w_level_next  = r_level + 1'b1;
                end else begin
                    w_level_next = r_level - 1'b1;
                end
            end
        end
    end

    assign w_duty = PWM_BITS'(w_level_next) << (PWM_BITS - LEVEL_BITS);

    // Scan FSM, process 3 of 3: output decode, folded into the LED mux.
    // Decoding next-state values lets LED move on the same edge as the state.
    always_comb begin
        w_led_next = '0;
        case (MODE)
            MODE_COUNT:   w_led_next = w_step_next;
            MODE_SCAN:    w_led_next = N_LEDS'(1) << w_pos_next;
            MODE_BLINK:   w_led_next = {N_LEDS{w_step_next[0]}};
            MODE_BREATHE: w_led_next = {N_LEDS{(r_pwm < w_duty)}};
            default:      w_led_next = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mode   <= MODE_COUNT;
            r_step   <= '0;
            r_level  <= '0;
            r_rising <= 1'b1;
            r_pwm    <= '0;
            r_led    <= '0;
        end else begin
            r_mode   <= MODE;
            r_step   <= w_step_next;
            r_level  <= w_level_next;
            r_rising <= w_rising_next;
            r_pwm    <= r_pwm + 1'b1;
            r_led    <= w_led_next;
        end
    end

    assign LED  = r_led;
    assign TICK = w_tick;

endmodule
